// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
// Holds the FSM state encoding, the word/lane geometry and the width of
// the wait-state counter, plus a small helper that turns lane enables
// into a 32-bit bit mask.

package mips_mem_pkg;

   localparam int BYTE_LANES     = 4;
   localparam int WORD_WIDTH     = 32;
   localparam int WAIT_CNT_WIDTH = 4;

   // IDLE: waiting for a request; BUSY: counting wait states and then
   // performing the access; RESP: one-cycle completion pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;
   typedef logic [BYTE_LANES-1:0]     lanes_t;
   typedef logic [WORD_WIDTH-1:0]     word_t;

   // Expand per-byte enables into a bit mask; lane i covers bits [8i+7:8i].
   function automatic word_t lane_mask(input lanes_t lanes);
      word_t m;
      m = '0;
      for (int i = 0; i < BYTE_LANES; i++) begin
         m[8*i +: 8] = {8{lanes[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/mips_data_memory_responder_if.sv
// Bus between the MEM stage (master) and the data-memory responder (slave).
//
// Handshake: the master raises MemRead and/or MemWrite together with
// Address, WriteData and ByteSig and keeps them stable while MemStall is
// high. The slave accepts the request on the first rising edge where it is
// idle and a request is present, freezes the pipeline through MemStall
// (combinational, high from the request cycle until the access is done),
// and reports completion with a single-cycle MemReady pulse in which
// MemReadData and AddrError are valid. MemStall is low during that pulse,
// so the edge that ends it is the edge on which the pipeline advances; the
// still-asserted request is ignored during the pulse and is not re-accepted.

interface mips_dmem_if;
   import mips_mem_pkg::*;

   logic   MemRead;
   logic   MemWrite;
   word_t  Address;
   word_t  WriteData;
   lanes_t ByteSig;
   word_t  MemReadData;
   logic   MemReady;
   logic   MemStall;
   logic   AddrError;

   // Pipeline side issues requests and consumes responses.
   modport master (
      output MemRead, MemWrite, Address, WriteData, ByteSig,
      input  MemReadData, MemReady, MemStall, AddrError
   );

   // Memory side consumes requests and produces responses.
   modport slave (
      input  MemRead, MemWrite, Address, WriteData, ByteSig,
      output MemReadData, MemReady, MemStall, AddrError
   );

endinterface

// File: rtl/mips_data_memory_responder_array.sv
// Word-organised single-port data RAM.
// One access per strobe: the addressed word is read into the output
// register and, when writing, the enabled byte lanes are updated on the
// same edge. The read returns the contents from before that edge's write.
// Contents are never cleared; only the surrounding control resets.

module mips_dmem_array
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  access_en,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] index,
   input  lanes_t                lane_we,
   input  word_t                 wdata,
   output word_t                 rdata
);

   word_t mem [DEPTH_WORDS];
   word_t rdata_q;

   // Storage and synchronous read, both qualified by the access strobe.
   always_ff @(posedge clk) begin
      if (access_en) begin
         rdata_q <= mem[index];
         if (write_en) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
               if (lane_we[i]) begin
                  mem[index][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mips_data_memory_responder.sv
// Memory-side responder for the MIPS MEM stage.
// Accepts one load/store at a time, stalls the pipeline for a programmable
// number of wait states, performs the access on the data RAM and returns a
// one-cycle MemReady pulse carrying read data and an address-error flag.
// Erroneous requests (out-of-range address, or read and write together)
// keep normal timing but never touch the RAM and return zero data.

module mips_data_memory_responder
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic            ClockIn,
   input  logic            Reset,
   mips_dmem_if.slave      bus,
   output state_e          dbg_state
);

   localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(WAIT_STATES);

   // FSM and request-latch registers.
   state_e                state_q,    state_d;
   wait_cnt_t             cnt_q,      cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q,      idx_d;
   word_t                 wdata_q,    wdata_d;
   lanes_t                lanes_q,    lanes_d;
   logic                  is_read_q,  is_read_d;
   logic                  is_write_q, is_write_d;
   logic                  err_q,      err_d;
   word_t                 rdata_q,    rdata_d;

   logic  req;
   logic  accept;
   logic  out_of_range;
   logic  bad_cmd;
   logic  access_en;
   logic  ram_write;
   word_t ram_rdata;
   word_t resp_data;

   // Byte-offset bits carry no meaning for a word-organised memory.
   logic  unused_addr_lsbs;
   assign unused_addr_lsbs = ^bus.Address[1:0];

   assign req          = bus.MemRead | bus.MemWrite;
   assign accept       = (state_q == IDLE) && req;
   assign out_of_range = |bus.Address[WORD_WIDTH-1:ADDR_WIDTH+2];
   assign bad_cmd      = bus.MemRead & bus.MemWrite;

   // The access happens on the edge that leaves BUSY. Gating with Reset
   // keeps a write abandoned by reset from landing on that same edge.
   assign access_en = Reset && (state_q == BUSY) && (cnt_q == '0);
   assign ram_write = is_write_q & ~err_q;

   mips_dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_array (
      .clk       (ClockIn),
      .access_en (access_en),
      .write_en  (ram_write),
      .index     (idx_q),
      .lane_we   (lanes_q),
      .wdata     (wdata_q),
      .rdata     (ram_rdata)
   );

   // Load data as returned to the pipeline: masked to the enabled lanes,
   // zero for stores and for any request that was flagged as an error.
   assign resp_data = (is_read_q && !err_q) ? (ram_rdata & lane_mask(lanes_q)) : '0;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge ClockIn) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         lanes_q    <= '0;
         is_read_q  <= 1'b0;
         is_write_q <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         lanes_q    <= lanes_d;
         is_read_q  <= is_read_d;
         is_write_q <= is_write_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   // Next-state logic: RESP always returns to IDLE so a held request is
   // only re-accepted after the pipeline has seen the completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = BUSY;
         BUSY:    if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latching, wait counting and capture of the returned data.
   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      lanes_d    = lanes_q;
      is_read_d  = is_read_q;
      is_write_d = is_write_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      if (accept) begin
         cnt_d      = WAIT_LOAD;
         idx_d      = bus.Address[ADDR_WIDTH+1:2];
         wdata_d    = bus.WriteData;
         lanes_d    = bus.ByteSig;
         is_read_d  = bus.MemRead;
         is_write_d = bus.MemWrite;
         err_d      = out_of_range | bad_cmd;
      end else if ((state_q == BUSY) && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
      // Keep the completed response so MemReadData holds after RESP.
      if (state_q == RESP) begin
         rdata_d = resp_data;
      end
   end

   // Outputs: stall covers the request cycle and all of BUSY, never RESP.
   always_comb begin
      bus.MemReady    = (state_q == RESP);
      bus.AddrError   = (state_q == RESP) && err_q;
      bus.MemReadData = (state_q == RESP) ? resp_data : rdata_q;
      bus.MemStall    = Reset && (accept || (state_q == BUSY));
      dbg_state       = state_q;
   end

endmodule

// File: tb/tb_mips_data_memory_responder.sv
// Self-checking bench for mips_data_memory_responder.
// Two instances: dut_a with two wait states and dut_b with none. A byte-level
// memory image per instance predicts load data; timing expectations come
// from the wait-state count (completion WAIT_STATES+1 edges after accept,
// stall for WAIT_STATES+2 cycles).

module tb_mips_data_memory_responder;
  import mips_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_dmem_if bus_a ();
  mips_dmem_if bus_b ();
  state_e dbg_a;
  state_e dbg_b;

  mips_data_memory_responder #(
    .DEPTH_WORDS (256),
    .ADDR_WIDTH  (8),
    .WAIT_STATES (2)
  ) dut_a (
    .ClockIn   (clk),
    .Reset     (rst_n),
    .bus       (bus_a),
    .dbg_state (dbg_a)
  );

  mips_data_memory_responder #(
    .DEPTH_WORDS (256),
    .ADDR_WIDTH  (8),
    .WAIT_STATES (0)
  ) dut_b (
    .ClockIn   (clk),
    .Reset     (rst_n),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mbytes [2][1024];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- observers ----------------
  function automatic logic [31:0] obs_data(input bit sel);
    return sel ? bus_b.MemReadData : bus_a.MemReadData;
  endfunction
  function automatic logic obs_ready(input bit sel);
    return sel ? bus_b.MemReady : bus_a.MemReady;
  endfunction
  function automatic logic obs_stall(input bit sel);
    return sel ? bus_b.MemStall : bus_a.MemStall;
  endfunction
  function automatic logic obs_err(input bit sel);
    return sel ? bus_b.AddrError : bus_a.AddrError;
  endfunction
  function automatic logic [1:0] obs_state(input bit sel);
    return sel ? dbg_b : dbg_a;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] lanes);
    if (sel) begin
      bus_b.MemRead = rd; bus_b.MemWrite = wr; bus_b.Address = addr;
      bus_b.WriteData = wdata; bus_b.ByteSig = lanes;
    end else begin
      bus_a.MemRead = rd; bus_a.MemWrite = wr; bus_a.Address = addr;
      bus_a.WriteData = wdata; bus_a.ByteSig = lanes;
    end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // One complete transaction with timing, error and data checks. The model
  // decides the error outcome and the load data from the byte image.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] lanes, input bit hold, input string tag);
    int ws;
    int edges;
    int stall_cycles;
    bit got;
    bit exp_err;
    int base;
    logic [31:0] exp_data;
    ws = sel ? 0 : 2;
    edges = 0;
    stall_cycles = 0;
    got = 1'b0;
    exp_err = (addr >= 32'd1024) || (rd && wr);
    base = int'(addr[9:2]) * 4;
    exp_data = 32'h0;
    if (rd && !exp_err) begin
      for (int i = 0; i < 4; i++)
        exp_data[8*i +: 8] = lanes[i] ? mbytes[sel][base+i] : 8'h00;
    end
    exp_q.push_back(exp_data);

    @(negedge clk);
    drive(sel, rd, wr, addr, wdata, lanes);
    #1;
    if (obs_stall(sel)) stall_cycles++;
    while (!got && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (obs_ready(sel)) got = 1'b1;
      else if (obs_stall(sel)) stall_cycles++;
    end
    check({tag, " ready"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(edges - 1), 32'(ws + 1));
    check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(ws + 2));
    check({tag, " stall_in_resp"}, 32'(obs_stall(sel)), 32'd0);
    check({tag, " addr_error"}, 32'(obs_err(sel)), 32'(exp_err));
    exp_data = exp_q.pop_front();
    if (rd || exp_err) check({tag, " read_data"}, obs_data(sel), exp_data);

    if (wr && !exp_err) begin
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mbytes[sel][base+i] = wdata[8*i +: 8];
    end

    if (hold) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " no_second_ready"}, 32'(obs_ready(sel)), 32'd0);
      check({tag, " data_holds"}, obs_data(sel), exp_data);
      check({tag, " error_low_after"}, 32'(obs_err(sel)), 32'd0);
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      @(negedge clk);
      check({tag, " not_reaccepted"}, 32'(obs_state(sel)), 32'(IDLE));
      check({tag, " still_no_ready"}, 32'(obs_ready(sel)), 32'd0);
    end else begin
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  lanes;
    int op;

    idle_all();
    rst_n = 1'b0;
    // A request held during reset must not raise stall.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall", 32'(bus_a.MemStall), 32'd0);
    check("reset ready", 32'(bus_a.MemReady), 32'd0);
    check("reset error", 32'(bus_a.AddrError), 32'd0);
    check("reset data", bus_a.MemReadData, 32'h0);
    check("reset state", 32'(dbg_a), 32'(IDLE));
    idle_all();
    rst_n = 1'b1;

    // 1: full store then full load.
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, "t1 store");
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "t1 load");
    check("t1 value", exp_q.size() == 0 ? obs_data(1'b0) : 32'hX, 32'hDEADBEEF);

    // 2: single-lane store merges into the existing word.
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0, "t2 store");
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "t2 load");
    check("t2 value", obs_data(1'b0), 32'hDEADAAEF);

    // 3: lane-masked load with the request held through the response.
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0011, 1'b1, "t3 load");
    check("t3 value", obs_data(1'b0), 32'h0000AAEF);

    // 4: error cases leave memory untouched.
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h11223344, 4'b1111, 1'b0, "t4 init");
    access(1'b0, 1'b0, 1'b1, 32'h00000400, 32'h99999999, 4'b1111, 1'b0, "t4 oor store");
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b1111, 1'b0, "t4 load0");
    check("t4 value", obs_data(1'b0), 32'h11223344);
    access(1'b0, 1'b1, 1'b1, 32'h0, 32'h55555555, 4'b1111, 1'b0, "t4 rdwr");
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b1111, 1'b0, "t4 reload0");
    check("t4 value2", obs_data(1'b0), 32'h11223344);

    // 5: reset during the second BUSY cycle of a store abandons it.
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b0, "t5 init");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    check("t5 busy1", 32'(dbg_a), 32'(BUSY));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5 stall_forced", 32'(bus_a.MemStall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
    #1;
    check("t5 state", 32'(dbg_a), 32'(IDLE));
    check("t5 stall", 32'(bus_a.MemStall), 32'd0);
    check("t5 ready", 32'(bus_a.MemReady), 32'd0);
    check("t5 data_cleared", bus_a.MemReadData, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("t5 no_late_ready", 32'(bus_a.MemReady), 32'd0);
    end
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, "t5 load");
    check("t5 old_word", obs_data(1'b0), 32'hCAFEF00D);

    // 6: zero-wait instance, last word, back to back.
    access(1'b1, 1'b0, 1'b1, 32'h3FC, 32'hA5A55A5A, 4'b1111, 1'b0, "t6 store");
    access(1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 4'b1111, 1'b0, "t6 load");
    check("t6 value", obs_data(1'b1), 32'hA5A55A5A);

    // Random traffic against the byte-image model on both instances.
    for (int w = 0; w < 16; w++)
      access(1'b0, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'b1111, 1'b0, "fill a");
    for (int w = 250; w < 256; w++)
      access(1'b1, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'b1111, 1'b0, "fill b");
    for (int k = 0; k < 40; k++) begin
      bit sel;
      sel   = (k % 4) == 3;
      op    = $urandom_range(0, 9);
      wdata = $urandom;
      lanes = 4'($urandom_range(0, 15));
      addr  = sel ? 32'($urandom_range(250, 255) * 4) : 32'($urandom_range(0, 15) * 4);
      addr[1:0] = 2'($urandom_range(0, 3));
      case (op)
        0:       access(sel, 1'b1, 1'b0, $urandom | 32'h400, wdata, lanes, 1'b0, "rnd oor");
        1:       access(sel, 1'b1, 1'b1, addr, wdata, lanes, 1'b0, "rnd rdwr");
        2, 3, 4: access(sel, 1'b0, 1'b1, addr, wdata, lanes, 1'b0, "rnd store");
        default: access(sel, 1'b1, 1'b0, addr, wdata, lanes, op == 9, "rnd load");
      endcase
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
